// File: rtl/counter_updown_mod.sv
// Up/down modulo counter (0..MAX_VAL) with wrap/saturate, clear, clamped load and boundary status.
// Latency: one clock per count update, tc combinational; no backpressure, a command is taken every cycle.
module counter_updown_mod #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             bound_evt,
  output logic             ovf_sticky
);

  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             bound_evt_q, bound_evt_d;
  logic             ovf_sticky_q, ovf_sticky_d;

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   step_up;
  logic [WIDTH:0]   step_dn;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH-1:0] load_clamped;
  logic             at_top;
  logic             at_bottom;
  logic             boundary;
  logic             tc_c;

  // The extra bit makes both boundaries visible without extra comparators:
  // stepping past MAX_VAL exceeds MAX_EXT, stepping below zero sets the borrow.
  always_comb begin
    count_ext    = {1'b0, count_q};
    step_up      = count_ext + ONE_EXT;
    step_dn      = count_ext - ONE_EXT;
    load_ext     = {1'b0, load_val};
    at_top       = (step_up > MAX_EXT);
    at_bottom    = step_dn[WIDTH];
    boundary     = up_dn ? at_top : at_bottom;
    tc_c         = en & ~clr & ~load & boundary;
    load_clamped = (load_ext > MAX_EXT) ? MAX_VAL : load_val;
  end

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = RESET_VAL;
    end else if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      if (boundary) begin
        if (!SATURATE) begin
          count_d = up_dn ? '0 : MAX_VAL;
        end
      end else begin
        count_d = up_dn ? step_up[WIDTH-1:0] : step_dn[WIDTH-1:0];
      end
    end
  end

  // A boundary step in the same cycle as ovf_clr keeps the flag set.
  always_comb begin
    bound_evt_d  = tc_c;
    ovf_sticky_d = tc_c | (ovf_sticky_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= RESET_VAL;
      bound_evt_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      bound_evt_q  <= bound_evt_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign count      = count_q;
  assign tc         = tc_c;
  assign bound_evt  = bound_evt_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: wrap and saturate instances driven in lockstep
// against an arithmetic reference model, directed steps then random traffic.
module tb_counter_updown_mod;

  localparam int W    = 4;
  localparam int MAXV = 9;
  localparam int RSTV = 0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, up_dn, clr, load, ovf_clr;
  logic [W-1:0] load_val;
  logic [W-1:0] count_w, count_s;
  logic         tc_w, tc_s, evt_w, evt_s, ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = wrapping instance, 1 = saturating instance.
  int mc[2];
  bit me[2];
  bit mo[2];

  always #5 clk = ~clk;

  counter_updown_mod #(
    .WIDTH(W), .MAX_VAL(4'(MAXV)), .SATURATE(1'b0), .RESET_VAL(4'(RSTV))
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(count_w), .tc(tc_w),
    .bound_evt(evt_w), .ovf_sticky(ovf_w)
  );

  counter_updown_mod #(
    .WIDTH(W), .MAX_VAL(4'(MAXV)), .SATURATE(1'b1), .RESET_VAL(4'(RSTV))
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(count_s), .tc(tc_s),
    .bound_evt(evt_s), .ovf_sticky(ovf_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Next count for an enabled step, from the counting rules alone.
  function automatic int step_val(input int c, input bit up, input bit sat);
    if (sat) begin
      if (up) return (c + 1 > MAXV) ? MAXV : c + 1;
      return (c - 1 < 0) ? 0 : c - 1;
    end
    return (c + (up ? 1 : MAXV)) % (MAXV + 1);
  endfunction

  function automatic bit exp_tc(input int c);
    return en && !clr && !load && ((up_dn && c == MAXV) || (!up_dn && c == 0));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mc[i] = RSTV;
      me[i] = 1'b0;
      mo[i] = 1'b0;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".count_w"}, {28'b0, count_w}, 32'(mc[0]));
    chk({tag, ".count_s"}, {28'b0, count_s}, 32'(mc[1]));
    chk({tag, ".evt_w"},   {31'b0, evt_w},   {31'b0, me[0]});
    chk({tag, ".evt_s"},   {31'b0, evt_s},   {31'b0, me[1]});
    chk({tag, ".ovf_w"},   {31'b0, ovf_w},   {31'b0, mo[0]});
    chk({tag, ".ovf_s"},   {31'b0, ovf_s},   {31'b0, mo[1]});
  endtask

  task automatic drive(input bit e, input bit u, input bit c, input bit l,
                       input logic [W-1:0] lv, input bit oc);
    en       = e;
    up_dn    = u;
    clr      = c;
    load     = l;
    load_val = lv;
    ovf_clr  = oc;
  endtask

  // Checks tc before the edge, advances the model on the edge, checks registers after it.
  task automatic do_cycle(input string tag);
    bit t[2];
    int lv;
    #1;
    t[0] = exp_tc(mc[0]);
    t[1] = exp_tc(mc[1]);
    chk({tag, ".tc_w"}, {31'b0, tc_w}, {31'b0, t[0]});
    chk({tag, ".tc_s"}, {31'b0, tc_s}, {31'b0, t[1]});
    @(posedge clk);
    lv = int'(load_val);
    for (int i = 0; i < 2; i++) begin
      me[i] = t[i];
      mo[i] = t[i] || (mo[i] && !ovf_clr);
      if (clr)       mc[i] = RSTV;
      else if (load) mc[i] = (lv > MAXV) ? MAXV : lv;
      else if (en)   mc[i] = step_val(mc[i], up_dn, i == 1);
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_regs("reset");
    chk("reset.tc_w", {31'b0, tc_w}, 32'd0);
    #1 rst_n = 1'b1;

    // Count up through the wrap point.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 12; i++) do_cycle($sformatf("up%0d", i));
    chk("up12.count_w_const", {28'b0, count_w}, 32'd2);
    chk("up12.ovf_w_const", {31'b0, ovf_w}, 32'd1);

    // Down from zero wraps to MAX_VAL.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    do_cycle("clr0");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    do_cycle("dn0");
    chk("dn0.count_w_const", {28'b0, count_w}, 32'd9);
    do_cycle("dn1");
    chk("dn1.count_w_const", {28'b0, count_w}, 32'd8);

    // Repeated steps at the top: saturating instance holds and keeps pulsing.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
    do_cycle("ld9");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle($sformatf("sat%0d", i));
    chk("sat.count_s_const", {28'b0, count_s}, 32'd9);

    // Priority: clr over load over en, then load clamped to MAX_VAL.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
    do_cycle("ld5");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0);
    do_cycle("prio_clr");
    chk("prio_clr.count_w_const", {28'b0, count_w}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0);
    do_cycle("clamp");
    chk("clamp.count_s_const", {28'b0, count_s}, 32'd9);

    // Sticky flag: clear without tc, then set wins over a simultaneous clear.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    do_cycle("ovf_clr");
    chk("ovf_clr.ovf_w_const", {31'b0, ovf_w}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    do_cycle("ovf_set_wins");
    chk("ovf_set_wins.ovf_w_const", {31'b0, ovf_w}, 32'd1);

    // Asynchronous reset between edges while counting.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
    do_cycle("ld5b");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    do_cycle("to6");
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("async_rst");
    @(posedge clk);
    #1;
    check_regs("rst_held");
    #2 rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    do_cycle("resume");
    chk("resume.count_w_const", {28'b0, count_w}, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
            4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
      do_cycle($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
